// File: rtl/simd_pkg.sv
// simd_pkg: shared definitions for the SIMD instruction-fetch front end.
//   OPCODE_WIDTH  width of the opcode field inside an instruction word
//   OP_HALT       opcode that terminates a program (all ones)
//   fetch_state_e sequencer states IDLE/RUN/DRAIN/DONE
package simd_pkg;

  localparam int OPCODE_WIDTH = 4;
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/simd_ins_mem.sv
// simd_ins_mem: simple dual-port inferred instruction RAM.
//   clk            core clock
//   wr_en/wr_addr/wr_data   write port (PS loads)
//   rd_en/rd_addr  read request
//   rd_data        read data, valid RD_LAT cycles after rd_en (1 or 2)
// A read and a write to the same address in one cycle return the old word.
module simd_ins_mem #(
  parameter int AW     = 11,
  parameter int DW     = 64,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_q <= mem[rd_addr];
  end

  if (RD_LAT == 2) begin : g_oreg
    logic [DW-1:0] out_q;
    always_ff @(posedge clk) out_q <= rd_q;
    assign rd_data = out_q;
  end else begin : g_noreg
    assign rd_data = rd_q;
  end

endmodule

// File: rtl/simd_fetch_seq.sv
// simd_fetch_seq: program sequencer and instruction-fetch front end.
// Runs a program out of simd_ins_mem and streams words through a prefetch
// FIFO whose occupancy plus outstanding reads never exceeds FIFO_DEPTH.
// Ports:
//   clk, rstn                async active-low reset
//   ins_wr_en/addr/data      PS write port (accepted in IDLE/DONE only)
//   start, abort, prog_len   program control (prog_len 0 = run until HALT)
//   busy, done, wr_err       status; done pulses one cycle in DONE
//   ins_valid/ins_ready      instruction stream; instruction, pc = payload
//   state_dbg                current sequencer state (fetch_state_e)
//   cyc_cnt, stall_cnt       only when SIMD_PERF_CNT_EN is defined
// Handshake: a word transfers on a cycle with ins_valid & ins_ready; while
// ins_valid is high and ins_ready low, instruction/pc hold and ins_valid
// stays high (unless abort).
module simd_fetch_seq
  import simd_pkg::*;
#(
  parameter int INS_ADDR_WIDTH = 11,
  parameter int INS_WIDTH      = 64,
  parameter int ADDR_WIDTH     = 10,
  parameter int RD_LAT         = 1,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      ins_wr_en,
  input  logic [INS_ADDR_WIDTH-1:0] ins_wr_addr,
  input  logic [INS_WIDTH-1:0]      ins_wr_data,
  input  logic                      start,
  input  logic                      abort,
  input  logic [INS_ADDR_WIDTH-1:0] prog_len,
  output logic                      busy,
  output logic                      done,
  output logic                      wr_err,
  output logic                      ins_valid,
  input  logic                      ins_ready,
  output logic [INS_WIDTH-1:0]      instruction,
  output logic [INS_ADDR_WIDTH-1:0] pc,
  output logic [1:0]                state_dbg
`ifdef SIMD_PERF_CNT_EN
  ,
  output logic [31:0]               cyc_cnt,
  output logic [31:0]               stall_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [INS_ADDR_WIDTH-1:0] ONE_A = 1;
  localparam logic [PTR_W-1:0]          ONE_P = 1;
  localparam logic [CNT_W-1:0]          ONE_C = 1;
  localparam logic [CNT_W:0]            DEPTH_X = FIFO_DEPTH;

  fetch_state_e state_q, state_d;
  logic [INS_ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic [INS_ADDR_WIDTH-1:0] len_q, len_d;
  logic halt_seen_q, halt_seen_d;
  logic wr_err_q, wr_err_d;
  // Read-return pipeline: one valid bit + address per outstanding read.
  logic [RD_LAT-1:0]                     rd_vld_q, rd_vld_d;
  logic [RD_LAT-1:0][INS_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [FIFO_DEPTH-1:0][INS_WIDTH-1:0]      fifo_data_q, fifo_data_d;
  logic [FIFO_DEPTH-1:0][INS_ADDR_WIDTH-1:0] fifo_pc_q, fifo_pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;

  logic [CNT_W-1:0] in_flight;
  logic [INS_WIDTH-1:0] ret_data;
  logic busy_w, start_ok, ret_vld, ret_halt, push, pop;
  logic credit_ok, fetch_en, last_fetch, mem_wr_en;

  simd_ins_mem #(.AW(INS_ADDR_WIDTH), .DW(INS_WIDTH), .RD_LAT(RD_LAT)) u_mem (
    .clk     (clk),
    .wr_en   (mem_wr_en),
    .wr_addr (ins_wr_addr),
    .wr_data (ins_wr_data),
    .rd_en   (fetch_en),
    .rd_addr (fetch_addr_q),
    .rd_data (ret_data)
  );

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + CNT_W'(rd_vld_q[i]);
  end

  assign busy_w    = (state_q == RUN) || (state_q == DRAIN);
  assign start_ok  = (state_q == IDLE) && start && !abort;
  assign ins_valid = busy_w && (fifo_cnt_q != '0);
  assign pop       = ins_valid && ins_ready;
  assign ret_vld   = rd_vld_q[RD_LAT-1];
  // Once HALT has been seen every later return is dropped.
  assign ret_halt  = ret_vld && !halt_seen_q &&
                     (ret_data[3*ADDR_WIDTH +: OPCODE_WIDTH] == OP_HALT);
  assign push      = ret_vld && !halt_seen_q && !ret_halt;
  assign credit_ok = ({1'b0, fifo_cnt_q} + {1'b0, in_flight}) < DEPTH_X;
  assign fetch_en  = (state_q == RUN) && !halt_seen_q && !ret_halt && credit_ok;
  assign last_fetch = fetch_en && (len_q != '0) && (fetch_addr_q == len_q - ONE_A);
  assign mem_wr_en = ins_wr_en && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    len_d        = len_q;
    halt_seen_d  = halt_seen_q;
    wr_err_d     = wr_err_q;
    rd_vld_d     = rd_vld_q;
    rd_addr_d    = rd_addr_q;
    fifo_data_d  = fifo_data_q;
    fifo_pc_d    = fifo_pc_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_cnt_d   = fifo_cnt_q;

    rd_vld_d[0]  = fetch_en;
    rd_addr_d[0] = fetch_addr_q;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_vld_d[i]  = rd_vld_q[i-1];
      rd_addr_d[i] = rd_addr_q[i-1];
    end
    if (fetch_en) fetch_addr_d = fetch_addr_q + ONE_A;
    if (ret_halt) halt_seen_d = 1'b1;

    if (push) begin
      fifo_data_d[wr_ptr_q] = ret_data;
      fifo_pc_d[wr_ptr_q]   = rd_addr_q[RD_LAT-1];
      wr_ptr_d              = wr_ptr_q + ONE_P;
    end
    if (pop) rd_ptr_d = rd_ptr_q + ONE_P;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + ONE_C;
      2'b01:   fifo_cnt_d = fifo_cnt_q - ONE_C;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    if (ins_wr_en && busy_w) wr_err_d = 1'b1;

    case (state_q)
      IDLE: if (start_ok) begin
        state_d      = RUN;
        fetch_addr_d = '0;
        len_d        = prog_len;
        halt_seen_d  = 1'b0;
        wr_err_d     = 1'b0;
      end
      RUN:   if (last_fetch || ret_halt) state_d = DRAIN;
      // Finish in the cycle the final word leaves so done follows it directly.
      DRAIN: if ((in_flight == '0) &&
                 ((fifo_cnt_q == '0) || ((fifo_cnt_q == ONE_C) && pop))) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (busy_w && abort) begin
      state_d     = IDLE;
      rd_vld_d    = '0;
      fifo_cnt_d  = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      halt_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      len_q        <= '0;
      halt_seen_q  <= 1'b0;
      wr_err_q     <= 1'b0;
      rd_vld_q     <= '0;
      rd_addr_q    <= '0;
      fifo_data_q  <= '0;
      fifo_pc_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      len_q        <= len_d;
      halt_seen_q  <= halt_seen_d;
      wr_err_q     <= wr_err_d;
      rd_vld_q     <= rd_vld_d;
      rd_addr_q    <= rd_addr_d;
      fifo_data_q  <= fifo_data_d;
      fifo_pc_q    <= fifo_pc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
    end
  end

  assign busy        = busy_w;
  assign done        = (state_q == DONE);
  assign wr_err      = wr_err_q;
  assign instruction = ins_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign pc          = ins_valid ? fifo_pc_q[rd_ptr_q] : '0;
  assign state_dbg   = state_q;

`ifdef SIMD_PERF_CNT_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    cyc_cnt_d   = cyc_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (start_ok) begin
      cyc_cnt_d   = '0;
      stall_cnt_d = '0;
    end else begin
      if (busy_w && (cyc_cnt_q != '1)) cyc_cnt_d = cyc_cnt_q + 32'd1;
      if (ins_valid && !ins_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cyc_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      cyc_cnt_q   <= cyc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign cyc_cnt   = cyc_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_simd_fetch_seq.sv
// tb_simd_fetch_seq: two DUT copies (RD_LAT=1 and RD_LAT=2) driven by the
// same stimulus; each output stream is compared with the word list derived
// from a shadow copy of the instruction memory.
module tb_simd_fetch_seq;
  import simd_pkg::OPCODE_WIDTH;
  import simd_pkg::OP_HALT;

  localparam int IA_W    = 11;
  localparam int INS_W   = 64;
  localparam int OPC_LSB = 30;
  localparam int EW      = IA_W + INS_W;
  localparam int MEM_N   = 2048;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic ins_wr_en = 1'b0;
  logic [IA_W-1:0] ins_wr_addr = '0;
  logic [INS_W-1:0] ins_wr_data = '0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [IA_W-1:0] prog_len = '0;
  logic ins_ready = 1'b0;

  logic busy_o [2];
  logic done_o [2];
  logic wr_err_o [2];
  logic vld_o [2];
  logic [INS_W-1:0] ins_o [2];
  logic [IA_W-1:0] pc_o [2];
  logic [1:0] st_o [2];
`ifdef SIMD_PERF_CNT_EN
  logic [31:0] cyc_cnt_o [2];
  logic [31:0] stall_cnt_o [2];
`endif

  for (genvar g = 0; g < 2; g++) begin : g_dut
    simd_fetch_seq #(.RD_LAT(g + 1), .FIFO_DEPTH(4)) u_dut (
      .clk         (clk),
      .rstn        (rstn),
      .ins_wr_en   (ins_wr_en),
      .ins_wr_addr (ins_wr_addr),
      .ins_wr_data (ins_wr_data),
      .start       (start),
      .abort       (abort),
      .prog_len    (prog_len),
      .busy        (busy_o[g]),
      .done        (done_o[g]),
      .wr_err      (wr_err_o[g]),
      .ins_valid   (vld_o[g]),
      .ins_ready   (ins_ready),
      .instruction (ins_o[g]),
      .pc          (pc_o[g]),
      .state_dbg   (st_o[g])
`ifdef SIMD_PERF_CNT_EN
      ,
      .cyc_cnt     (cyc_cnt_o[g]),
      .stall_cnt   (stall_cnt_o[g])
`endif
    );
  end

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model + scoreboard
  logic [INS_W-1:0] model_mem [MEM_N];
  logic [EW-1:0] exp_q[$];

  function automatic logic [INS_W-1:0] rand_word(input bit halt);
    logic [INS_W-1:0] w;
    w = {$urandom, $urandom};
    w[OPC_LSB +: OPCODE_WIDTH] = halt ? OP_HALT : OPCODE_WIDTH'($urandom_range(0, 14));
    return w;
  endfunction

  // Expected stream: addresses from 0 upward, prog_len words (or forever
  // when 0), cut short before the first HALT word.
  task automatic build_exp(input int len);
    int a;
    logic [INS_W-1:0] w;
    a = 0;
    exp_q.delete();
    while ((len == 0 || exp_q.size() < len) && exp_q.size() < MEM_N) begin
      w = model_mem[a];
      if (w[OPC_LSB +: OPCODE_WIDTH] == OP_HALT) break;
      exp_q.push_back({IA_W'(a), w});
      a = (a + 1) % MEM_N;
    end
  endtask

  // monitor (negedge sampling)
  int cyc = 0;
  int start_cyc = 0;
  int idx [2];
  int done_cnt [2];
  int done_cyc [2];
  int first_vld [2];
  int first_xfer [2];
  int last_xfer [2];
  bit stall_prev [2];
  logic [EW-1:0] mon_e;

  always @(negedge clk) begin
    cyc++;
    if (start && !abort && rstn) begin
      start_cyc = cyc;
      for (int k = 0; k < 2; k++) begin
        idx[k] = 0; done_cnt[k] = 0; done_cyc[k] = -1;
        first_vld[k] = -1; first_xfer[k] = -1; last_xfer[k] = -1;
      end
    end
    if (rstn) begin
      for (int k = 0; k < 2; k++) begin
        if (stall_prev[k]) check("hold_valid", 64'(vld_o[k]), 64'd1);
        if (vld_o[k]) begin
          if (first_vld[k] < 0) first_vld[k] = cyc;
          check("in_range", 64'(idx[k] < exp_q.size()), 64'd1);
          if (idx[k] < exp_q.size()) begin
            mon_e = exp_q[idx[k]];
            check("pc", 64'(pc_o[k]), 64'(mon_e[INS_W +: IA_W]));
            check("instr", ins_o[k], mon_e[INS_W-1:0]);
          end
          if (ins_ready) begin
            if (first_xfer[k] < 0) first_xfer[k] = cyc;
            last_xfer[k] = cyc;
            idx[k]++;
          end
        end
        stall_prev[k] = vld_o[k] && !ins_ready;
        if (done_o[k]) begin
          done_cnt[k]++;
          done_cyc[k] = cyc;
        end
      end
    end
  end

  // driver tasks
  task automatic ps_write(input int a, input logic [INS_W-1:0] d);
    @(posedge clk); #1;
    ins_wr_en = 1'b1; ins_wr_addr = IA_W'(a); ins_wr_data = d;
    @(posedge clk); #1;
    ins_wr_en = 1'b0;
    model_mem[a] = d;
  endtask

  // mode: 0 ready=1, 1 toggle, 2 stalled 20 cycles, 3 random
  task automatic run_prog(input int len, input int mode, input int abort_after,
                          input bit wr_busy, input bit exact_done);
    bit finished;
    bit aborted;
    build_exp(len);
    @(posedge clk); #1;
    prog_len = IA_W'(len);
    start = 1'b1;
    ins_ready = (mode == 2) ? 1'b0 : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 2; k++) check("wr_err_clr", 64'(wr_err_o[k]), 64'd0);
    finished = 1'b0;
    aborted = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      case (mode)
        0: ins_ready = 1'b1;
        1: ins_ready = (n % 2) == 1;
        2: ins_ready = (n >= 20);
        default: ins_ready = 1'($urandom_range(0, 1));
      endcase
      if (wr_busy && n == 4) begin
        ins_wr_en = 1'b1; ins_wr_addr = IA_W'(2); ins_wr_data = rand_word(1'b0);
      end
      if (abort_after >= 0 && idx[0] >= abort_after) begin
        abort = 1'b1;
        aborted = 1'b1;
      end
      @(posedge clk); #1;
      abort = 1'b0;
      ins_wr_en = 1'b0;
      if (aborted) break;
      if (done_cnt[0] > 0 && done_cnt[1] > 0) begin
        finished = 1'b1;
        break;
      end
    end
    if (aborted) begin
      for (int k = 0; k < 2; k++) begin
        check("abort_valid", 64'(vld_o[k]), 64'd0);
        check("abort_busy", 64'(busy_o[k]), 64'd0);
      end
      repeat (6) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) check("abort_no_done", 64'(done_cnt[k]), 64'd0);
    end else begin
      repeat (3) @(posedge clk);
      #1;
      check("timeout", 64'(finished), 64'd1);
      for (int k = 0; k < 2; k++) begin
        check("count", 64'(idx[k]), 64'(exp_q.size()));
        check("done_once", 64'(done_cnt[k]), 64'd1);
        check("busy_end", 64'(busy_o[k]), 64'd0);
        if (exp_q.size() > 0) begin
          check("first_lat", 64'((first_vld[k] - start_cyc) >= (k + 2)), 64'd1);
          if (exact_done) check("done_lat", 64'(done_cyc[k] - last_xfer[k]), 64'd1);
          if (mode == 0) check("b2b", 64'(last_xfer[k] - first_xfer[k]), 64'(exp_q.size() - 1));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_N; i++) model_mem[i] = '0;
    for (int k = 0; k < 2; k++) begin
      idx[k] = 0; done_cnt[k] = 0; stall_prev[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_busy", 64'(busy_o[k]), 64'd0);
      check("rst_done", 64'(done_o[k]), 64'd0);
      check("rst_wr_err", 64'(wr_err_o[k]), 64'd0);
      check("rst_valid", 64'(vld_o[k]), 64'd0);
      check("rst_pc", 64'(pc_o[k]), 64'd0);
      check("rst_instr", ins_o[k], 64'd0);
    end
    rstn = 1'b1;

    for (int a = 0; a < 32; a++) ps_write(a, rand_word(1'b0));

    run_prog(8, 0, -1, 1'b0, 1'b1);
    run_prog(16, 1, -1, 1'b0, 1'b1);
    run_prog(int'($urandom_range(12, 30)), 3, -1, 1'b0, 1'b1);
    run_prog(12, 2, -1, 1'b0, 1'b1);

    ps_write(5, rand_word(1'b1));
    run_prog(0, 0, -1, 1'b0, 1'b0);
    run_prog(10, 3, -1, 1'b0, 1'b0);
    ps_write(5, rand_word(1'b0));

    run_prog(10, 0, 3, 1'b0, 1'b0);
    run_prog(10, 0, -1, 1'b0, 1'b1);

    // abort together with start in IDLE keeps the sequencer idle
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; prog_len = IA_W'(8);
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) check("abort_start_idle", 64'(busy_o[k]), 64'd0);

    // write while busy is dropped and flags wr_err until the next start
    run_prog(16, 1, -1, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) check("wr_err_set", 64'(wr_err_o[k]), 64'd1);
    run_prog(16, 0, -1, 1'b0, 1'b1);

    for (int r = 0; r < 3; r++)
      run_prog(int'($urandom_range(1, 32)), int'($urandom_range(0, 3)), -1, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
